// File: rtl/buzzer_tone.sv
// Memory-mapped buzzer peripheral: programmable tone divider plus an on/off/repeat
// beep pattern that plays autonomously and reports BUSY/DONE.
//   state | meaning
//   IDLE  | pin low, counters held at 0
//   ON    | tone running, counting ON_MS ticks
//   OFF   | pin forced low, counting OFF_MS ticks
module buzzer_tone #(
    parameter int ADDRWIDTH  = 4,
    parameter int CLK_PER_MS = 50000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr,
    input  logic [ADDRWIDTH-1:0] waddr,
    input  logic [31:0]          wdata,
    input  logic                 rd,
    input  logic [ADDRWIDTH-1:0] raddr,
    output logic [31:0]          rdata,
    output logic                 buzzer_pin
);

    localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          cont_q, done_q;
    logic [15:0]   div_q;
    logic [31:0]   time_q;
    logic [7:0]    repeat_q;
    logic [7:0]    rep_left_q;
    logic [15:0]   on_ms_q, off_ms_q;
    logic [15:0]   ms_cnt_q;
    logic [PW-1:0] presc_q;
    logic [15:0]   tone_q;

    logic wr_ctrl, wr_div, wr_time, wr_rep;
    logic start, stop, clr_done;
    logic tick, on_last, off_last;
    logic load_seq, restart_on, set_done, dec_rep, ms_clr;
    logic unused_addr_bits;

    assign unused_addr_bits = ^{waddr[1:0], raddr[1:0]};

    assign wr_ctrl  = wr && (waddr[3:2] == 2'd0);
    assign wr_div   = wr && (waddr[3:2] == 2'd1);
    assign wr_time  = wr && (waddr[3:2] == 2'd2);
    assign wr_rep   = wr && (waddr[3:2] == 2'd3);
    assign start    = wr_ctrl && wdata[0];
    assign stop     = wr_ctrl && wdata[1];
    assign clr_done = wr_ctrl && wdata[3];

    assign tick     = (state_q != IDLE) && (presc_q == PW'(CLK_PER_MS - 1));
    assign on_last  = tick && (ms_cnt_q == on_ms_q - 16'd1);
    assign off_last = tick && (ms_cnt_q == off_ms_q - 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // STOP wins over START; a running sequence only reacts to pattern events otherwise
    always_comb begin
        state_d    = state_q;
        load_seq   = 1'b0;
        restart_on = 1'b0;
        set_done   = 1'b0;
        dec_rep    = 1'b0;
        ms_clr     = 1'b0;
        if (stop) begin
            state_d = IDLE;
        end else if (start) begin
            state_d  = ON;
            load_seq = 1'b1;
        end else begin
            case (state_q)
                ON: begin
                    if (on_last && !cont_q) begin
                        ms_clr = 1'b1;
                        if (rep_left_q == 8'd1) begin
                            state_d  = IDLE;
                            set_done = 1'b1;
                        end else begin
                            dec_rep = 1'b1;
                            if (off_ms_q == 16'd0) begin
                                state_d    = ON;
                                restart_on = 1'b1;
                            end else begin
                                state_d = OFF;
                            end
                        end
                    end
                end
                OFF: begin
                    if (off_last) begin
                        state_d    = ON;
                        restart_on = 1'b1;
                        ms_clr     = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cont_q     <= 1'b0;
            done_q     <= 1'b0;
            div_q      <= '0;
            time_q     <= '0;
            repeat_q   <= '0;
            rep_left_q <= '0;
            on_ms_q    <= '0;
            off_ms_q   <= '0;
            ms_cnt_q   <= '0;
            presc_q    <= '0;
            tone_q     <= '0;
            buzzer_pin <= 1'b0;
        end else begin
            if (wr_ctrl) cont_q   <= wdata[2];
            if (wr_div)  div_q    <= wdata[15:0];
            if (wr_time) time_q   <= wdata;
            if (wr_rep)  repeat_q <= wdata[7:0];

            // a DONE-setting transition beats a simultaneous CLR_DONE
            if (set_done)                   done_q <= 1'b1;
            else if (load_seq || clr_done)  done_q <= 1'b0;

            if (load_seq) begin
                on_ms_q    <= (time_q[15:0] == 16'd0) ? 16'd1 : time_q[15:0];
                off_ms_q   <= time_q[31:16];
                rep_left_q <= (repeat_q == 8'd0) ? 8'd1 : repeat_q;
            end else if (dec_rep) begin
                rep_left_q <= rep_left_q - 8'd1;
            end

            if (state_d == IDLE || load_seq || tick)
                presc_q <= '0;
            else
                presc_q <= presc_q + 1'b1;

            if (state_d == IDLE || load_seq || ms_clr)
                ms_cnt_q <= '0;
            else if (tick && !(state_q == ON && cont_q))
                ms_cnt_q <= ms_cnt_q + 16'd1;

            if (state_d != ON || load_seq || restart_on || div_q == 16'd0) begin
                tone_q     <= '0;
                buzzer_pin <= 1'b0;
            end else if (tone_q == div_q - 16'd1) begin
                tone_q     <= '0;
                buzzer_pin <= ~buzzer_pin;
            end else begin
                tone_q <= tone_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (rd) begin
            case (raddr[3:2])
                2'd0:    rdata <= {27'b0, cont_q, state_q, done_q, (state_q != IDLE)};
                2'd1:    rdata <= {16'b0, div_q};
                2'd2:    rdata <= time_q;
                default: rdata <= {16'b0, rep_left_q, repeat_q};
            endcase
        end
    end

endmodule

// File: tb/tb_buzzer_tone.sv
// Directed bench for buzzer_tone: expected values are queued as stimulus is driven
// and popped when the DUT output (pin or read data) is sampled.
module tb_buzzer_tone;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [3:0]  waddr = '0;
    logic [3:0]  raddr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        buzzer_pin;

    int errors = 0;
    int checks = 0;
    string       tag_q[$];
    logic [31:0] val_q[$];

    buzzer_tone #(.ADDRWIDTH(4), .CLK_PER_MS(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr         (wr),
        .waddr      (waddr),
        .wdata      (wdata),
        .rd         (rd),
        .raddr      (raddr),
        .rdata      (rdata),
        .buzzer_pin (buzzer_pin)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        val_q.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        checks++;
        if (val_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed 0x%08h with nothing expected", obs);
        end else begin
            t = tag_q.pop_front();
            e = val_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed 0x%08h expected 0x%08h", t, obs, e);
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
        wr = 1'b1; waddr = a; wdata = d;
        cyc(1);
        wr = 1'b0;
    endtask

    task automatic rd_reg(input logic [3:0] a, input logic [31:0] exp, input string tag);
        rd = 1'b1; raddr = a;
        push(tag, exp);
        cyc(1);
        rd = 1'b0;
        check(rdata);
    endtask

    task automatic pin_chk(input string tag, input logic exp);
        push(tag, {31'b0, exp});
        check({31'b0, buzzer_pin});
    endtask

    initial begin
        bit pending;
        int seg;

        // reset
        cyc(3);
        rst_n = 1'b1;
        cyc(1);
        pin_chk("reset_pin", 1'b0);
        push("reset_rdata", 32'h0);
        check(rdata);
        rd_reg(4'h0, 32'h0, "reset_ctrl");

        // single beep: DIV=3, ON 2 ms
        wr_reg(4'h4, 32'd3);
        wr_reg(4'h8, 32'h0000_0002);
        wr_reg(4'hC, 32'd1);
        wr_reg(4'h0, 32'h1);
        for (int k = 1; k <= 20; k++) begin
            cyc(1);
            pin_chk($sformatf("single_pin_%0d", k), (k >= 20) ? 1'b0 : 1'((k / 3) % 2));
        end
        rd_reg(4'h0, 32'h2, "single_done");

        // pattern: DIV=2, ON 1, OFF 1, three beeps
        wr_reg(4'h4, 32'd2);
        wr_reg(4'h8, 32'h0001_0001);
        wr_reg(4'hC, 32'd3);
        wr_reg(4'h0, 32'h1);
        pending = 1'b0;
        for (int k = 1; k <= 52; k++) begin
            cyc(1);
            if (pending) begin
                rd = 1'b0;
                check(rdata);
                pending = 1'b0;
            end
            seg = k / 10;
            pin_chk($sformatf("pattern_pin_%0d", k),
                    (seg % 2 == 0 && seg < 5) ? 1'(((k % 10) / 2) % 2) : 1'b0);
            case (k)
                5:  begin rd = 1'b1; raddr = 4'hC; push("rep_left_a", 32'h0000_0303); pending = 1'b1; end
                25: begin rd = 1'b1; raddr = 4'hC; push("rep_left_b", 32'h0000_0203); pending = 1'b1; end
                45: begin rd = 1'b1; raddr = 4'hC; push("rep_left_c", 32'h0000_0103); pending = 1'b1; end
                49: begin rd = 1'b1; raddr = 4'h0; push("pattern_busy_at_50", 32'h5); pending = 1'b1; end
                50: begin rd = 1'b1; raddr = 4'h0; push("pattern_done_after_50", 32'h2); pending = 1'b1; end
                default: ;
            endcase
        end

        // STOP mid-beep, then START+STOP while idle
        wr_reg(4'h4, 32'd3);
        wr_reg(4'h8, 32'h0000_0005);
        wr_reg(4'hC, 32'd1);
        wr_reg(4'h0, 32'h1);
        cyc(12);
        rd_reg(4'h0, 32'h5, "stop_pre_busy");
        wr_reg(4'h0, 32'h2);
        pin_chk("stop_pin", 1'b0);
        rd_reg(4'h0, 32'h0, "stop_ctrl");
        wr_reg(4'h0, 32'h3);
        rd_reg(4'h0, 32'h0, "start_stop_idle");

        // silent beep: DIV=0, REPEAT=0 treated as 1
        wr_reg(4'h4, 32'd0);
        wr_reg(4'h8, 32'h0000_0001);
        wr_reg(4'hC, 32'd0);
        wr_reg(4'h0, 32'h1);
        for (int k = 1; k <= 8; k++) begin
            cyc(1);
            pin_chk($sformatf("silent_pin_%0d", k), 1'b0);
        end
        rd_reg(4'hC, 32'h0000_0100, "silent_rep");
        cyc(1);
        rd_reg(4'h0, 32'h2, "silent_done");

        // restart while busy
        wr_reg(4'h4, 32'd2);
        wr_reg(4'h8, 32'h0001_0002);
        wr_reg(4'hC, 32'd2);
        wr_reg(4'h0, 32'h1);
        cyc(24);
        rd_reg(4'hC, 32'h0000_0102, "restart_rep_before");
        rd_reg(4'h0, 32'h9, "restart_off_state");
        wr_reg(4'h0, 32'h1);
        rd_reg(4'hC, 32'h0000_0202, "restart_rep_reload");
        rd_reg(4'h0, 32'h5, "restart_done_clear");

        // continuous mode
        wr_reg(4'h0, 32'h5);
        cyc(1000);
        rd_reg(4'h0, 32'h15, "cont_busy");
        wr_reg(4'h0, 32'h2);
        rd_reg(4'h0, 32'h0, "cont_stopped");

        // CLR_DONE
        wr_reg(4'h8, 32'h0000_0001);
        wr_reg(4'hC, 32'd1);
        wr_reg(4'h0, 32'h1);
        cyc(12);
        rd_reg(4'h0, 32'h2, "clr_pre_done");
        wr_reg(4'h0, 32'h8);
        rd_reg(4'h0, 32'h0, "clr_done");

        // reset during OFF
        wr_reg(4'h8, 32'h0001_0001);
        wr_reg(4'hC, 32'd3);
        wr_reg(4'h0, 32'h1);
        cyc(14);
        rd_reg(4'h0, 32'h9, "pre_reset_off");
        rst_n = 1'b0;
        #1;
        pin_chk("reset_mid_pin", 1'b0);
        push("reset_mid_rdata", 32'h0);
        check(rdata);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        rd_reg(4'h0, 32'h0, "post_reset_ctrl");
        rd_reg(4'h4, 32'h0, "post_reset_div");
        rd_reg(4'h8, 32'h0, "post_reset_time");
        rd_reg(4'hC, 32'h0, "post_reset_rep");
        cyc(3);
        pin_chk("post_reset_pin", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
